// File: rtl/mips_avalon_pkg.sv
// Shared types and constants for the Avalon-MM word RAM slave.
package mips_avalon_pkg;

  // Default byte address of word 0 (MIPS reset vector region).
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hBFC00000;

  // Transaction FSM states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_ACK
  } state_t;

  // Avalon response codes.
  typedef enum logic [1:0] {
    RESP_OKAY        = 2'b00,
    RESP_SLAVEERROR  = 2'b10,
    RESP_DECODEERROR = 2'b11
  } resp_t;

endpackage

// File: rtl/mips_byte_ram.sv
// Byte-enabled synchronous word RAM.
// One shared address: the controller never reads and writes in the same cycle.
module mips_byte_ram #(
  parameter int    DEPTH_WORDS = 1024,
  parameter string INIT_FILE   = "",
  localparam int   AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  input  logic          re,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane writes and registered read port.
  // NOTE: the array and its output register have no reset; storage must survive reset, and
  // the controller masks rdata until the first successful read.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mips_avalon_resp_ram.sv
// Avalon-MM slave word RAM with programmable read/write wait states.
// Configuration macro MIPS_AVALON_RESP_EN: when defined, adds the response port plus
// alignment, byte-enable, read+write and address-decode error checking. When undefined,
// misaligned addresses truncate to the word and bad accesses complete silently.
module mips_avalon_resp_ram
  import mips_avalon_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          READ_DELAY  = 2,
  parameter int          WRITE_DELAY = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address,
  input  logic [3:0]  byteenable,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata
`ifdef MIPS_AVALON_RESP_EN
  ,
  output logic [1:0]  response
`endif
);

  localparam int          AW     = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN   = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  RD_DLY = 4'(READ_DELAY);
  localparam logic [3:0]  WR_DLY = 4'(WRITE_DELAY);

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic        rd_q, wr_q;
  logic        zero_rd;
  logic [31:0] ram_q;

  // Transaction view: live bus in IDLE (zero-delay ops decide there), latched copy afterwards.
  logic        req;
  logic [31:0] cur_addr, offset;
  logic [3:0]  cur_be;
  logic        cur_rd, cur_wr;
  logic        in_range, lane_ok, rd_ok, wr_ok, rd_zero, enter_ack;

  assign req      = read | write;
  assign cur_addr = (state == ST_IDLE) ? address    : addr_q;
  assign cur_be   = (state == ST_IDLE) ? byteenable : be_q;
  assign cur_rd   = (state == ST_IDLE) ? read       : rd_q;
  assign cur_wr   = (state == ST_IDLE) ? write      : wr_q;
  assign offset   = cur_addr - BASE_ADDR;
  assign in_range = {1'b0, offset} < SPAN;

`ifdef MIPS_AVALON_RESP_EN
  assign lane_ok = (cur_addr[1:0] == 2'b00) && (cur_be != 4'b0000);
  assign rd_zero = cur_rd & ~in_range;
`else
  assign lane_ok = 1'b1;
  assign rd_zero = cur_rd & (~in_range | cur_wr);
`endif

  assign rd_ok = cur_rd & ~cur_wr & in_range & lane_ok;
  assign wr_ok = cur_wr & ~cur_rd & in_range & lane_ok;

  // Next-state and wait-state counter; read+write together uses the read delay.
  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    logic [3:0] dly;
    state_next = state;
    cnt_next   = cnt;
    dly        = (write && !read) ? WR_DLY : RD_DLY;
    case (state)
      ST_IDLE: begin
        if (req) begin
          cnt_next   = dly;
          state_next = (dly == 4'd0) ? ST_ACK : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!req) begin
          state_next = ST_IDLE;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt - 4'd1;
          if (cnt <= 4'd1) state_next = ST_ACK;
        end
      end
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign enter_ack   = (state != ST_ACK) && (state_next == ST_ACK);
  assign waitrequest = ((state == ST_IDLE) && req) || (state == ST_BUSY);

  // State and counter registers.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Capture the request when it is accepted in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else if (state == ST_IDLE && req) begin
      addr_q  <= address;
      wdata_q <= writedata;
      be_q    <= byteenable;
      rd_q    <= read;
      wr_q    <= write;
    end
  end

  // Selects between RAM data and forced zero; only read ACKs may change what readdata shows.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zero_rd <= 1'b1;
    end else if (enter_ack) begin
      if (rd_ok)        zero_rd <= 1'b0;
      else if (rd_zero) zero_rd <= 1'b1;
    end
  end

  assign readdata = zero_rd ? 32'h0 : ram_q;

  // Read issued on the edge into ACK so data is valid during ACK; writes commit at the end of ACK.
  mips_byte_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .addr  (offset[AW+1:2]),
    .we    ((state == ST_ACK) && wr_ok),
    .be    (cur_be),
    .wdata (wdata_q),
    .re    (enter_ack && rd_ok),
    .rdata (ram_q)
  );

`ifdef MIPS_AVALON_RESP_EN
  // Response is only meaningful in ACK and reads OKAY everywhere else.
  always_comb begin
    response = RESP_OKAY;
    if (state == ST_ACK) begin
      if (!in_range)                         response = RESP_DECODEERROR;
      else if ((cur_rd && cur_wr) || !lane_ok) response = RESP_SLAVEERROR;
    end
  end
`endif

endmodule

// File: tb/tb_mips_avalon_resp_ram.sv
// Scoreboard bench for mips_avalon_resp_ram: drivers queue expected ACK results,
// per-DUT monitors pop and compare whenever waitrequest drops under an active request.
module tb_mips_avalon_resp_ram;

`ifdef MIPS_AVALON_RESP_EN
  localparam bit RESP_EN = 1'b1;
`else
  localparam bit RESP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [31:0] a_address, a_writedata, a_readdata;
  logic [3:0]  a_be;
  logic        a_read, a_write, a_wait;
  logic [31:0] b_address, b_writedata, b_readdata;
  logic [3:0]  b_be;
  logic        b_read, b_write, b_wait;
`ifdef MIPS_AVALON_RESP_EN
  logic [1:0]  a_resp, b_resp;
`endif

  mips_avalon_resp_ram u_a (
    .clk(clk), .reset_n(reset_n), .address(a_address), .byteenable(a_be),
    .read(a_read), .write(a_write), .writedata(a_writedata),
    .waitrequest(a_wait), .readdata(a_readdata)
`ifdef MIPS_AVALON_RESP_EN
    , .response(a_resp)
`endif
  );

  mips_avalon_resp_ram #(.READ_DELAY(0), .WRITE_DELAY(5)) u_b (
    .clk(clk), .reset_n(reset_n), .address(b_address), .byteenable(b_be),
    .read(b_read), .write(b_write), .writedata(b_writedata),
    .waitrequest(b_wait), .readdata(b_readdata)
`ifdef MIPS_AVALON_RESP_EN
    , .response(b_resp)
`endif
  );

  typedef struct {
    string       name;
    bit          chk_rd;
    logic [31:0] rd;
    logic [1:0]  resp;
    int          lat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pops one expectation per ACK (waitrequest low with request high) and compares.
  task automatic monitor(input bit sel);
    int          cyc = 0;
    exp_t        e;
    logic        req, wt;
    logic [31:0] rdat;
    logic [1:0]  rsp;
    forever begin
      @(negedge clk);
      req  = sel ? (b_read | b_write) : (a_read | a_write);
      wt   = sel ? b_wait : a_wait;
      rdat = sel ? b_readdata : a_readdata;
`ifdef MIPS_AVALON_RESP_EN
      rsp  = sel ? b_resp : a_resp;
`else
      rsp  = 2'b00;
`endif
      if (!req) begin
        cyc = 0;
      end else begin
        cyc++;
        if (!wt) begin
          if ((sel ? qb.size() : qa.size()) == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack: dut %0d acked with nothing queued", sel);
          end else begin
            if (sel) e = qb.pop_front();
            else     e = qa.pop_front();
            check({e.name, "_lat"}, 32'(cyc), 32'(e.lat));
            if (e.chk_rd) check({e.name, "_rdata"}, rdat, e.rd);
            if (RESP_EN) check({e.name, "_resp"}, {30'b0, rsp}, {30'b0, e.resp});
          end
          cyc = 0;
        end
      end
    end
  endtask

  initial monitor(1'b0);
  initial monitor(1'b1);

  // Queues the expectation, presents the request and holds it until the ACK cycle passes.
  task automatic access(input bit sel, input string name, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data,
                        input bit chk_rd, input logic [31:0] exp_rd, input logic [1:0] exp_resp,
                        input int lat);
    exp_t e;
    bit   done = 1'b0;
    e.name = name; e.chk_rd = chk_rd; e.rd = exp_rd; e.resp = exp_resp; e.lat = lat;
    if (sel) begin
      qb.push_back(e);
      b_read = rd; b_write = wr; b_address = addr; b_be = be; b_writedata = data;
    end else begin
      qa.push_back(e);
      a_read = rd; a_write = wr; a_address = addr; a_be = be; a_writedata = data;
    end
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (sel ? !b_wait : !a_wait) done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: no ack within 64 cycles", name);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_read = 1'b0; a_write = 1'b0;
    b_read = 1'b0; b_write = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic rd_a(input string name, input logic [31:0] addr, input logic [31:0] exp_rd,
                      input logic [1:0] exp_resp);
    access(1'b0, name, 1'b1, 1'b0, addr, 4'hF, 32'h0, 1'b1, exp_rd, exp_resp, 4);
    idle();
  endtask

  task automatic wr_a(input string name, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] data, input logic [1:0] exp_resp);
    access(1'b0, name, 1'b0, 1'b1, addr, be, data, 1'b0, 32'h0, exp_resp, 4);
    idle();
  endtask

  initial begin
    reset_n = 1'b0;
    a_read = 1'b0; a_write = 1'b0; a_address = '0; a_be = '0; a_writedata = '0;
    b_read = 1'b0; b_write = 1'b0; b_address = '0; b_be = '0; b_writedata = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("reset_rdata", a_readdata, 32'h0);
    check("reset_wait", {31'b0, a_wait}, 32'h0);
`ifdef MIPS_AVALON_RESP_EN
    check("reset_resp", {30'b0, a_resp}, 32'h0);
`endif
    @(posedge clk);
    #1;

    // Basic write/read and partial byte-lane write.
    wr_a("w_word0", 32'hBFC00000, 4'hF, 32'h24020005, 2'b00);
    rd_a("r_word0", 32'hBFC00000, 32'h24020005, 2'b00);
    wr_a("w_word4_clr", 32'hBFC00010, 4'hF, 32'h00000000, 2'b00);
    wr_a("w_word4_be5", 32'hBFC00010, 4'b0101, 32'hAABBCCDD, 2'b00);
    rd_a("r_word4", 32'hBFC00010, 32'h00BB00DD, 2'b00);

    // Misaligned: error keeps readdata, otherwise truncates to word 0.
    rd_a("r_misalign", 32'hBFC00002, RESP_EN ? 32'h00BB00DD : 32'h24020005, 2'b10);
    rd_a("r_decode_zero", 32'h00000000, 32'h0, 2'b11);

    // Zero byteenable write changes nothing.
    wr_a("w_be0", 32'hBFC00010, 4'b0000, 32'hFFFFFFFF, 2'b10);
    rd_a("r_word4_after_be0", 32'hBFC00010, 32'h00BB00DD, 2'b00);

    // Simultaneous read+write: read timing, no write committed.
    access(1'b0, "rw_both", 1'b1, 1'b1, 32'hBFC00000, 4'hF, 32'h0, 1'b1,
           RESP_EN ? 32'h00BB00DD : 32'h0, 2'b10, 4);
    idle();
    rd_a("r_word0_after_rw", 32'hBFC00000, 32'h24020005, 2'b00);

    // Address range boundaries.
    wr_a("w_last", 32'hBFC00FFC, 4'hF, 32'h12345678, 2'b00);
    rd_a("r_last", 32'hBFC00FFC, 32'h12345678, 2'b00);
    wr_a("w_past_end", 32'hBFC01000, 4'hF, 32'h55555555, 2'b11);
    rd_a("r_past_end", 32'hBFC01000, 32'h0, 2'b11);
    rd_a("r_below_base", 32'hBFBFFFFC, 32'h0, 2'b11);

    // Write dropped in the second BUSY cycle aborts without committing.
    a_address = 32'hBFC00010; a_writedata = 32'h11111111; a_be = 4'hF; a_write = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 a_write = 1'b0;
    @(negedge clk);
    check("abort_busy_wait", {31'b0, a_wait}, 32'h1);
    @(negedge clk);
    check("abort_idle_wait", {31'b0, a_wait}, 32'h0);
    @(posedge clk);
    #1;
    rd_a("r_word4_after_abort", 32'hBFC00010, 32'h00BB00DD, 2'b00);

    // Reset during a write's BUSY phase: op dropped, readdata cleared, RAM kept.
    rd_a("r_word0_pre_reset", 32'hBFC00000, 32'h24020005, 2'b00);
    a_address = 32'hBFC00000; a_writedata = 32'hDEADBEEF; a_be = 4'hF; a_write = 1'b1;
    @(posedge clk);
    #1 a_write = 1'b0;
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("rst_mid_wait", {31'b0, a_wait}, 32'h0);
    check("rst_mid_rdata", a_readdata, 32'h0);
`ifdef MIPS_AVALON_RESP_EN
    check("rst_mid_resp", {30'b0, a_resp}, 32'h0);
`endif
    @(posedge clk);
    #1;
    rd_a("r_word0_post_reset", 32'hBFC00000, 32'h24020005, 2'b00);

    // Second instance: zero read delay, five write wait states, back-to-back requests.
    access(1'b1, "b_w_word1", 1'b0, 1'b1, 32'hBFC00004, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0, 2'b00, 7);
    access(1'b1, "b_r_word1", 1'b1, 1'b0, 32'hBFC00004, 4'hF, 32'h0, 1'b1, 32'hCAFEF00D, 2'b00, 2);
    access(1'b1, "b_w_word2", 1'b0, 1'b1, 32'hBFC00008, 4'hF, 32'h01020304, 1'b0, 32'h0, 2'b00, 7);
    access(1'b1, "b_r_word2", 1'b1, 1'b0, 32'hBFC00008, 4'hF, 32'h0, 1'b1, 32'h01020304, 2'b00, 2);
    idle();
    access(1'b1, "b_r_decode", 1'b1, 1'b0, 32'h00000000, 4'hF, 32'h0, 1'b1, 32'h0, 2'b11, 2);
    idle();

    repeat (2) @(posedge clk);
    check("qa_drained", 32'(qa.size()), 32'h0);
    check("qb_drained", 32'(qb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
